rst_capture_fifo_4bit: RTL and testbench
========================================

RST_CAPTURE_FIFO_4BIT -- requirements
Module: rst_capture_fifo_4bit

Interface
REQ-001 Parameter: DEPTH, 4, number of FIFO entries; power of two, minimum 2.
REQ-002 Parameter: WIDTH, 5, entry width: 4 gated data bits plus 1 register bit.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: in_valid  input  1  upstream sample valid.
REQ-006 Port: in_data  input  4  gated data vector, bit i = upstream out_i.
REQ-007 Port: in_q  input  1  upstream registered bit q.
REQ-008 Port: in_ready  output  1  FIFO can accept a sample this cycle.
REQ-009 Port: out_valid  output  1  head entry available.
REQ-010 Port: out_data  output  WIDTH  head entry, {in_q, in_data} order.
REQ-011 Port: out_ready  input  1  downstream accepts the head entry.
REQ-012 Port: count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 Port: overflow  output  1  sticky flag: a sample was offered while full.

Function
REQ-014 Push occurs when in_valid && in_ready; {in_q, in_data} is written at the write pointer.
REQ-015 Pop occurs when out_valid && out_ready; the read pointer advances.
REQ-016 in_ready = (count < DEPTH), combinational from registered count only; no dependence on out_ready.
REQ-017 out_valid = (count != 0); out_data driven from storage at the read pointer; no bypass path.
REQ-018 Latency: a sample pushed at edge N is visible on out_data/out_valid after edge N; first pop possible at edge N+1.
REQ-019 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-020 Full (count == DEPTH): in_ready = 0, no write, even if out_ready = 1 in that cycle.
REQ-021 Empty (count == 0): out_data holds the last read location value; out_ready is ignored.
REQ-022 Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without a gap.
REQ-023 in_valid while count == DEPTH sets overflow at the next edge; overflow clears only on rst.
REQ-024 count changes by at most 1 per cycle.

Reset
REQ-025 rst asserted: count = 0, both pointers = 0, overflow = 0, out_valid = 0, in_ready = 1, immediately and without a clock edge.
REQ-026 Storage contents are not reset; out_data is don't-care while count == 0.
REQ-027 rst mid-operation discards all entries; the first push after release is the first entry popped.
REQ-028 rst deassertion is synchronised externally; no push or pop occurs on the edge coincident with release.

Configuration
REQ-029 Macro RST_CAPTURE_PARITY_EN defined: each entry stores an extra even-parity bit of {in_q, in_data}, and an output port out_parity (1 bit) gives the stored parity of the head entry.
REQ-030 RST_CAPTURE_PARITY_EN undefined: the parity bit, its storage and the out_parity port are absent; all other behaviour is identical.

Structure
REQ-031 Package rst_capture_pkg holds WIDTH and DEPTH defaults, the pointer width constant, and the entry typedef (data, q, optional parity).
REQ-032 One sub-module, rst_capture_mem, holds the DEPTH x entry register array with one write port and one asynchronous read port; pointer, count and flag logic stay in the top.

Verification
REQ-033 Reset then push 0x1A, 0x05, 0x1F -> pops return 0x1A, 0x05, 0x1F in order; count goes 1, 2, 3, then 2, 1, 0.
REQ-034 Fill 4 entries, hold out_ready = 0 and in_valid = 1 -> in_ready = 0, count = 4, overflow = 1 the next cycle, contents unchanged.
REQ-035 Count = 2 with push and pop in the same cycle for 10 cycles -> count stays 2, data order preserved across pointer wrap.
REQ-036 Assert rst between clock edges with count = 3 -> count = 0, out_valid = 0, overflow = 0 immediately; next push 0x11 is the next pop.
REQ-037 Full FIFO, out_ready = 1 and in_valid = 1 -> a pop occurs with no push; count = 3 after the edge.
REQ-038 RST_CAPTURE_PARITY_EN defined, push 0x07 -> out_parity = 1; push 0x03 -> out_parity = 0.

Source files
------------

// File: rtl/rst_capture_pkg.sv
// Shared types and defaults for the reset-capture FIFO.
// RST_CAPTURE_PARITY_EN adds a stored even-parity bit per entry.
package rst_capture_pkg;

   localparam int DEPTH_DEF = 4;
   localparam int WIDTH_DEF = 5;
   localparam int PTR_W     = $clog2(DEPTH_DEF);

   typedef struct packed {
`ifdef RST_CAPTURE_PARITY_EN
      logic       p;
`endif
      logic       q;
      logic [3:0] data;
   } entry_t;

   function automatic logic even_par(input logic q, input logic [3:0] d);
      return ^{q, d};
   endfunction

endpackage

// File: rtl/rst_capture_mem.sv
// Entry storage: one write port, one asynchronous read port.
// Contents are deliberately left unreset.
module rst_capture_mem
   import rst_capture_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  entry_t        wdata_i,
   input  logic [AW-1:0] raddr_i,
   output entry_t        rdata_o
);

   entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rst_capture_fifo_4bit.sv
// Capture FIFO for {q, gated data} samples with sticky overflow.
// Define RST_CAPTURE_PARITY_EN to add the out_parity port.
module rst_capture_fifo_4bit
   import rst_capture_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [3:0]             in_data,
   input  logic                   in_q,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
`ifdef RST_CAPTURE_PARITY_EN
   output logic                   out_parity,
`endif
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          push, pop, full;
   entry_t        wr_ent, rd_ent;

   assign full      = (count_q == CW'(DEPTH));
   assign in_ready  = !full;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      wr_ent      = '0;
      wr_ent.q    = in_q;
      wr_ent.data = in_data;
`ifdef RST_CAPTURE_PARITY_EN
      wr_ent.p    = even_par(in_q, in_data);
`endif
   end

   rst_capture_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (wr_ent),
      .raddr_i (rptr_q),
      .rdata_o (rd_ent)
   );

   assign out_data = WIDTH'({rd_ent.q, rd_ent.data});
`ifdef RST_CAPTURE_PARITY_EN
   assign out_parity = rd_ent.p;
`endif

   // Power-of-two depth lets the pointers wrap naturally.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q | (in_valid & full);
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_rst_capture_fifo_4bit.sv
// Directed self-checking bench for rst_capture_fifo_4bit.
// Parity checks are compiled in with RST_CAPTURE_PARITY_EN.
module tb_rst_capture_fifo_4bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_q;
   logic       in_ready;
   logic       out_valid;
   logic [4:0] out_data;
   logic       out_ready;
   logic [2:0] count;
   logic       overflow;
`ifdef RST_CAPTURE_PARITY_EN
   logic       out_parity;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   rst_capture_fifo_4bit #(.DEPTH(4), .WIDTH(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_q       (in_q),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
`ifdef RST_CAPTURE_PARITY_EN
      .out_parity (out_parity),
`endif
      .out_ready  (out_ready),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] s,
                        input logic r);
      in_valid  = v;
      in_q      = s[4];
      in_data   = s[3:0];
      out_ready = r;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'h00, 1'b0);
      #2;
      chk("rst_count", 32'(count), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_ovf",   32'(overflow), 0);
      step();
      rst = 1'b0;
      step();

      // in-order push then pop
      drive(1'b1, 5'h1A, 1'b0); step();
      chk("p1_count", 32'(count), 1);
      chk("p1_head",  32'(out_data), 32'h1A);
      chk("p1_valid", 32'(out_valid), 1);
      drive(1'b1, 5'h05, 1'b0); step();
      chk("p2_count", 32'(count), 2);
      drive(1'b1, 5'h1F, 1'b0); step();
      chk("p3_count", 32'(count), 3);
      drive(1'b0, 5'h00, 1'b1);
      chk("pop1_data", 32'(out_data), 32'h1A); step();
      chk("pop1_count", 32'(count), 2);
      chk("pop2_data", 32'(out_data), 32'h05); step();
      chk("pop2_count", 32'(count), 1);
      chk("pop3_data", 32'(out_data), 32'h1F); step();
      chk("pop3_count", 32'(count), 0);
      chk("empty_valid", 32'(out_valid), 0);
      step();
      chk("empty_pop_ignored", 32'(count), 0);

      // fill, then offer while full
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'(i), 1'b0); step();
      end
      chk("full_count", 32'(count), 4);
      chk("full_ready", 32'(in_ready), 0);
      chk("full_ovf_pre", 32'(overflow), 0);
      drive(1'b1, 5'h1E, 1'b0); step();
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_count", 32'(count), 4);
      chk("ovf_head", 32'(out_data), 32'h01);

      // full with both sides active: pop only
      drive(1'b1, 5'h1D, 1'b1); step();
      chk("fullpp_count", 32'(count), 3);
      chk("fullpp_head", 32'(out_data), 32'h02);
      drive(1'b0, 5'h00, 1'b1);
      for (int i = 2; i <= 4; i++) begin
         chk("drain_data", 32'(out_data), 32'(i)); step();
      end
      chk("drain_count", 32'(count), 0);
      chk("ovf_sticky", 32'(overflow), 1);

      // steady push+pop at count 2 across pointer wrap
      drive(1'b1, 5'h10, 1'b0); step();
      drive(1'b1, 5'h11, 1'b0); step();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 5'(8'h12 + i), 1'b1);
         chk("pp_data", 32'(out_data), 32'h10 + i);
         step();
         chk("pp_count", 32'(count), 2);
      end
      drive(1'b0, 5'h00, 1'b1);
      chk("pp_tail0", 32'(out_data), 32'h1A); step();
      chk("pp_tail1", 32'(out_data), 32'h1B); step();
      chk("pp_empty", 32'(count), 0);

      // asynchronous reset mid-operation
      drive(1'b1, 5'h05, 1'b0); step();
      drive(1'b1, 5'h06, 1'b0); step();
      drive(1'b1, 5'h07, 1'b0); step();
      drive(1'b0, 5'h00, 1'b0);
      chk("pre_rst_count", 32'(count), 3);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_ovf",   32'(overflow), 0);
      chk("arst_ready", 32'(in_ready), 1);
      step();
      rst = 1'b0;
      step();
      drive(1'b1, 5'h11, 1'b0); step();
      drive(1'b1, 5'h02, 1'b0); step();
      drive(1'b0, 5'h00, 1'b1);
      chk("post_rst_head", 32'(out_data), 32'h11); step();
      chk("post_rst_next", 32'(out_data), 32'h02); step();
      chk("post_rst_empty", 32'(count), 0);

`ifdef RST_CAPTURE_PARITY_EN
      drive(1'b1, 5'h07, 1'b0); step();
      drive(1'b1, 5'h03, 1'b0); step();
      drive(1'b0, 5'h00, 1'b1);
      chk("par_07", 32'(out_parity), 1); step();
      chk("par_03", 32'(out_parity), 0); step();
`endif

      drive(1'b0, 5'h00, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
